// File: rtl/rv_pkg.sv
// Shared RV32I definitions used by the fetch and decode stages.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic logic [XLEN-1:0] nextSeqPc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

    // Redirect targets are word-aligned by dropping the low bits, never trapped.
    function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
        return pc & ~32'h3;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC selection: redirect beats stall beats sequential advance.
module pc_reg #(
    parameter logic [31:0] RESET_PC = rv_pkg::RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirectPc_i,
    output logic [31:0] pc_o
);
    import rv_pkg::*;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = nextSeqPc(pc_q);
        if (redirect_i) begin
            pc_d = alignPc(redirectPc_i);
        end else if (stall_i) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: drives the imem address from the PC and captures the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC  = rv_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ifid_pc,
    output logic [31:0]      ifid_pc4,
    output logic [31:0]      ifid_instr,
    output logic             ifid_valid,
    output logic [CNT_W-1:0] fetch_count
);
    import rv_pkg::*;

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  ifidPc_q, ifidPc_d;
    logic [XLEN-1:0]  ifidPc4_q, ifidPc4_d;
    logic [XLEN-1:0]  ifidInstr_q, ifidInstr_d;
    logic             ifidValid_q, ifidValid_d;
    logic [CNT_W-1:0] fetchCount_q, fetchCount_d;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pcReg (
        .clk_i       (clk),
        .rst_i       (rst),
        .stall_i     (stall),
        .redirect_i  (redirect),
        .redirectPc_i(redirect_pc),
        .pc_o        (pc)
    );

    // A bubble keeps the old pc/pc4 so decode never sees a wrong-path address.
    always_comb begin
        ifidPc_d     = ifidPc_q;
        ifidPc4_d    = ifidPc4_q;
        ifidInstr_d  = ifidInstr_q;
        ifidValid_d  = ifidValid_q;
        fetchCount_d = fetchCount_q;
        if (redirect || flush) begin
            ifidInstr_d = NOP_INSTR;
            ifidValid_d = 1'b0;
        end else if (!stall) begin
            ifidPc_d     = pc;
            ifidPc4_d    = nextSeqPc(pc);
            ifidInstr_d  = imem_rdata;
            ifidValid_d  = 1'b1;
            fetchCount_d = fetchCount_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifidPc_q     <= '0;
            ifidPc4_q    <= '0;
            ifidInstr_q  <= NOP_INSTR;
            ifidValid_q  <= 1'b0;
            fetchCount_q <= '0;
        end else begin
            ifidPc_q     <= ifidPc_d;
            ifidPc4_q    <= ifidPc4_d;
            ifidInstr_q  <= ifidInstr_d;
            ifidValid_q  <= ifidValid_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    assign imem_addr   = pc;
    assign ifid_pc     = ifidPc_q;
    assign ifid_pc4    = ifidPc4_q;
    assign ifid_instr  = ifidInstr_q;
    assign ifid_valid  = ifidValid_q;
    assign fetch_count = fetchCount_q;

endmodule
